// File: rtl/cascade_slave_responder.sv
// cascade_slave_responder: slave-side INTA responder for the 8259A cascade bus.
// Synchronises inta_n and cas_in, follows the INTA pulse sequence, and drives
// the vector byte when the master selects this slave on the CAS lines.
// Optional MCS-80/85 three-pulse CALL sequence: define MCS80_MODE_EN.
module cascade_slave_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       inta_n,
    input  logic [2:0] cas_in,
    input  logic [2:0] slave_id,
    input  logic [4:0] vector_base,
    input  logic       irq_pending,
    input  logic [2:0] irq_level,
    input  logic       aeoi,
`ifdef MCS80_MODE_EN
    input  logic [7:0] addr_hi,
    input  logic [2:0] addr_lo_base,
    input  logic       adi,
`endif
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       isr_set,
    output logic [2:0] isr_level,
    output logic       auto_eoi,
    output logic       seq_abort,
    output logic       selected
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK1  = 3'd1,
        WAIT2 = 3'd2,
        ACK2  = 3'd3,
        WAIT3 = 3'd4,
        ACK3  = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t                 state;
    logic [SYNC_STAGES-1:0] inta_sync;
    logic [2:0]             cas_sync [SYNC_STAGES];
    logic                   inta_prev;
    logic                   inta_s;
    logic [2:0]             cas_s;
    logic                   fall;
    logic                   rise;
    logic [7:0]             cnt;
    logic [7:0]             cnt_next;
    logic                   timeout_hit;
    logic                   oe_r;
    logic [7:0]             out_r;
    logic [7:0]             byte2;

`ifdef MCS80_MODE_EN
    // Low CALL address byte: interval 4 keeps all three base bits, interval 8 keeps two.
    function automatic logic [7:0] mcs_low_byte(input logic [2:0] base,
                                                input logic [2:0] lvl,
                                                input logic       interval4);
        if (interval4)
            mcs_low_byte = {base, lvl, 2'b00};
        else
            mcs_low_byte = {base[2:1], lvl, 3'b000};
    endfunction
`endif

    assign inta_s      = inta_sync[SYNC_STAGES-1];
    assign cas_s       = cas_sync[SYNC_STAGES-1];
    assign fall        = inta_prev & ~inta_s;
    assign rise        = ~inta_prev & inta_s;
    assign cnt_next    = cnt + 8'd1;
    assign timeout_hit = (cnt_next == TIMEOUT_LIM);

`ifdef MCS80_MODE_EN
    assign byte2 = mcs_low_byte(addr_lo_base, isr_level, adi);
`else
    assign byte2 = {vector_base, isr_level};
`endif

    // Losing slave mode takes us off the bus at once, without waiting for a clock.
    assign data_oe  = oe_r & enable;
    assign data_out = data_oe ? out_r : 8'h00;

    // Bring the asynchronous INTA strobe and CAS lines into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_sync <= '1;
            inta_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++)
                cas_sync[i] <= 3'd0;
        end else begin
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
            inta_prev <= inta_s;
            cas_sync[0] <= cas_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                cas_sync[i] <= cas_sync[i-1];
        end
    end

    // INTA sequence tracker with registered bus-drive and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            isr_level <= 3'd0;
            isr_set   <= 1'b0;
            auto_eoi  <= 1'b0;
            seq_abort <= 1'b0;
            selected  <= 1'b0;
            oe_r      <= 1'b0;
            out_r     <= 8'h00;
        end else begin
            isr_set   <= 1'b0;
            auto_eoi  <= 1'b0;
            seq_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && enable) begin
                        // A request that vanished before INTA is reported as IR7.
                        isr_level <= irq_pending ? irq_level : 3'd7;
                        isr_set   <= irq_pending;
                        state     <= ACK1;
                    end
                end
                ACK1: begin
                    if (rise) begin
                        selected <= (cas_s == slave_id);
                        cnt      <= 8'd0;
                        state    <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        oe_r  <= selected;
                        out_r <= byte2;
                        state <= ACK2;
                    end else if (timeout_hit) begin
                        seq_abort <= 1'b1;
                        selected  <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        oe_r  <= 1'b0;
                        out_r <= 8'h00;
`ifdef MCS80_MODE_EN
                        cnt   <= 8'd0;
                        state <= WAIT3;
`else
                        auto_eoi <= aeoi & selected & enable;
                        selected <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
`ifdef MCS80_MODE_EN
                WAIT3: begin
                    if (fall) begin
                        oe_r  <= selected;
                        out_r <= addr_hi;
                        state <= ACK3;
                    end else if (timeout_hit) begin
                        seq_abort <= 1'b1;
                        selected  <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ACK3: begin
                    if (rise) begin
                        oe_r     <= 1'b0;
                        out_r    <= 8'h00;
                        auto_eoi <= aeoi & selected & enable;
                        selected <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Scoreboard bench for cascade_slave_responder: stimulus pushes expected
// output events (kind, value, cycle); a negedge monitor pops and compares.
// Define MCS80_MODE_EN to exercise the three-pulse build.
module tb_cascade_slave_responder;

    localparam int EV_ISR   = 0;
    localparam int EV_SELR  = 1;
    localparam int EV_SELF  = 2;
    localparam int EV_DOER  = 3;
    localparam int EV_DOEF  = 4;
    localparam int EV_EOI   = 5;
    localparam int EV_ABORT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       inta_n = 1'b1;
    logic [2:0] cas_in = 3'd0;
    logic [2:0] slave_id = 3'd3;
    logic [4:0] vector_base = 5'h09;
    logic       irq_pending = 1'b1;
    logic [2:0] irq_level = 3'd2;
    logic       aeoi = 1'b0;
`ifdef MCS80_MODE_EN
    logic [7:0] addr_hi = 8'h00;
    logic [2:0] addr_lo_base = 3'd0;
    logic       adi = 1'b0;
`endif
    logic [7:0] data_out;
    logic       data_oe;
    logic       isr_set;
    logic [2:0] isr_level;
    logic       auto_eoi;
    logic       seq_abort;
    logic       selected;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    cascade_slave_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .inta_n(inta_n),
        .cas_in(cas_in), .slave_id(slave_id), .vector_base(vector_base),
        .irq_pending(irq_pending), .irq_level(irq_level), .aeoi(aeoi),
`ifdef MCS80_MODE_EN
        .addr_hi(addr_hi), .addr_lo_base(addr_lo_base), .adi(adi),
`endif
        .data_out(data_out), .data_oe(data_oe), .isr_set(isr_set),
        .isr_level(isr_level), .auto_eoi(auto_eoi), .seq_abort(seq_abort),
        .selected(selected)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_ISR:   ev_name = "isr_set";
            EV_SELR:  ev_name = "selected_rise";
            EV_SELF:  ev_name = "selected_fall";
            EV_DOER:  ev_name = "data_oe_rise";
            EV_DOEF:  ev_name = "data_oe_fall";
            EV_EOI:   ev_name = "auto_eoi";
            default:  ev_name = "seq_abort";
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] val, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor side: match an observed output event against the scoreboard.
    task automatic see_ev(input int kind, input logic [7:0] val);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].kind == kind) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected %s at cycle %0d: got val %0h, required no event", ev_name(kind), cyc, val);
        end else begin
            if (exp_q[idx].val !== val || exp_q[idx].at != cyc) begin
                errors++;
                $display("FAIL %s: got val %0h at cycle %0d, required val %0h at cycle %0d",
                         ev_name(kind), val, cyc, exp_q[idx].val, exp_q[idx].at);
            end
            exp_q.delete(idx);
        end
    endtask

    initial begin : monitor
        logic       prev_oe;
        logic       prev_sel;
        logic [7:0] prev_out;
        prev_oe  = 1'b0;
        prev_sel = 1'b0;
        prev_out = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_oe  = 1'b0;
                prev_sel = 1'b0;
                prev_out = 8'h00;
            end else begin
                if (isr_set)               see_ev(EV_ISR, {5'd0, isr_level});
                if (selected && !prev_sel) see_ev(EV_SELR, 8'h00);
                if (!selected && prev_sel) see_ev(EV_SELF, 8'h00);
                if (data_oe && !prev_oe)   see_ev(EV_DOER, data_out);
                if (!data_oe && prev_oe)   see_ev(EV_DOEF, 8'h00);
                if (auto_eoi)              see_ev(EV_EOI, 8'h00);
                if (seq_abort)             see_ev(EV_ABORT, 8'h00);
                if (data_oe && prev_oe)    check("data_out_hold", {24'd0, data_out}, {24'd0, prev_out});
                if (!data_oe && prev_oe)   check("data_out_idle_zero", {24'd0, data_out}, 32'd0);
                prev_oe  = data_oe;
                prev_sel = selected;
                prev_out = data_out;
            end
        end
    end

    // Two-pulse 8086 sequence; irq_level is disturbed after INTA1 to show it is latched.
    task automatic two_pulse(input logic [2:0] cas, input bit exp_isr, input logic [2:0] lvl,
                             input bit exp_sel, input logic [7:0] b2, input bit exp_eoi);
        int c0 = cyc;
        if (exp_isr) expect_ev(EV_ISR, {5'd0, lvl}, c0 + 3);
        if (exp_sel) begin
            expect_ev(EV_SELR, 8'h00, c0 + 7);
            expect_ev(EV_DOER, b2, c0 + 11);
            expect_ev(EV_DOEF, 8'h00, c0 + 15);
            expect_ev(EV_SELF, 8'h00, c0 + 15);
            if (exp_eoi) expect_ev(EV_EOI, 8'h00, c0 + 15);
        end
        cas_in = cas;
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        irq_level = ~irq_level;
        tick(4);
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        tick(6);
    endtask

`ifdef MCS80_MODE_EN
    task automatic three_pulse(input logic [2:0] cas, input bit exp_isr, input logic [2:0] lvl,
                               input bit exp_sel, input logic [7:0] b2, input logic [7:0] b3,
                               input bit exp_eoi);
        int c0 = cyc;
        if (exp_isr) expect_ev(EV_ISR, {5'd0, lvl}, c0 + 3);
        if (exp_sel) begin
            expect_ev(EV_SELR, 8'h00, c0 + 7);
            expect_ev(EV_DOER, b2, c0 + 11);
            expect_ev(EV_DOEF, 8'h00, c0 + 15);
            expect_ev(EV_DOER, b3, c0 + 19);
            expect_ev(EV_DOEF, 8'h00, c0 + 23);
            expect_ev(EV_SELF, 8'h00, c0 + 23);
            if (exp_eoi) expect_ev(EV_EOI, 8'h00, c0 + 23);
        end
        cas_in = cas;
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        irq_level = ~irq_level;
        for (int p = 0; p < 2; p++) begin
            tick(4);
            inta_n = 1'b0;
            tick(4);
            inta_n = 1'b1;
        end
        tick(6);
    endtask
`endif

    // INTA1 only, then silence: abort 255 cycles after the sequence enters WAIT2.
    task automatic timeout_seq(input logic [2:0] lvl);
        int c0 = cyc;
        expect_ev(EV_ISR, {5'd0, lvl}, c0 + 3);
        expect_ev(EV_SELR, 8'h00, c0 + 7);
        expect_ev(EV_ABORT, 8'h00, c0 + 262);
        expect_ev(EV_SELF, 8'h00, c0 + 262);
        cas_in = slave_id;
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        tick(270);
    endtask

    // Reset pulled while the slave is driving the second INTA byte.
    task automatic reset_mid(input logic [2:0] lvl, input logic [7:0] b2);
        int c0 = cyc;
        expect_ev(EV_ISR, {5'd0, lvl}, c0 + 3);
        expect_ev(EV_SELR, 8'h00, c0 + 7);
        expect_ev(EV_DOER, b2, c0 + 11);
        cas_in = slave_id;
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        tick(4);
        inta_n = 1'b0;
        tick(5);
        check("pre_reset_oe", {31'd0, data_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_oe", {31'd0, data_oe}, 32'd0);
        check("reset_async_outputs",
              {16'd0, data_out, isr_set, isr_level, auto_eoi, seq_abort, selected}, 32'd0);
        inta_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        tick(3);
        check("reset_state",
              {15'd0, data_oe, data_out, isr_set, isr_level, auto_eoi, seq_abort, selected}, 32'd0);
        rst_n = 1'b1;
        tick(2);

`ifdef MCS80_MODE_EN
        // adi=1, base 101, IR6 -> low byte B8, high byte 3C
        adi = 1'b1; addr_lo_base = 3'b101; addr_hi = 8'h3C; irq_level = 3'd6; aeoi = 1'b1;
        three_pulse(3'd3, 1'b1, 3'd6, 1'b1, 8'hB8, 8'h3C, 1'b1);
        // adi=0, base 101, IR6 -> {10,110,000} = B0
        adi = 1'b0; addr_hi = 8'hA5; irq_level = 3'd6; aeoi = 1'b0;
        three_pulse(3'd3, 1'b1, 3'd6, 1'b1, 8'hB0, 8'hA5, 1'b0);
        // not selected
        irq_level = 3'd2; aeoi = 1'b1;
        three_pulse(3'd5, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00, 1'b0);
        aeoi = 1'b0;
        irq_level = 3'd4;
        timeout_seq(3'd4);
        adi = 1'b1; irq_level = 3'd1;
        reset_mid(3'd1, 8'hA4);
        irq_level = 3'd6; addr_hi = 8'h3C;
        three_pulse(3'd3, 1'b1, 3'd6, 1'b1, 8'hB8, 8'h3C, 1'b0);
`else
        // basic select: {01001,010} = 4A
        irq_level = 3'd2;
        two_pulse(3'd3, 1'b1, 3'd2, 1'b1, 8'h4A, 1'b0);
        // not selected: CAS=5
        irq_level = 3'd2;
        two_pulse(3'd5, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
        // spurious: {10000,111} = 87, no isr_set
        irq_pending = 1'b0; vector_base = 5'h10; irq_level = 3'd2;
        two_pulse(3'd3, 1'b0, 3'd7, 1'b1, 8'h87, 1'b0);
        // auto-EOI selected: {11111,001} = F9
        irq_pending = 1'b1; vector_base = 5'h1F; irq_level = 3'd1; aeoi = 1'b1;
        two_pulse(3'd3, 1'b1, 3'd1, 1'b1, 8'hF9, 1'b1);
        // auto-EOI but not selected: no auto_eoi
        irq_level = 3'd1;
        two_pulse(3'd6, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0);
        // all-zero boundary: slave 0, base 0, IR0 -> 00 while driving
        aeoi = 1'b0; slave_id = 3'd0; vector_base = 5'h00; irq_level = 3'd0;
        two_pulse(3'd0, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0);
        // disabled block ignores INTA entirely
        slave_id = 3'd3; vector_base = 5'h09; enable = 1'b0; irq_level = 3'd2;
        two_pulse(3'd3, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0);
        enable = 1'b1;
        // timeout, then a fresh sequence: {01001,101} = 4D
        irq_level = 3'd4;
        timeout_seq(3'd4);
        irq_level = 3'd5;
        two_pulse(3'd3, 1'b1, 3'd5, 1'b1, 8'h4D, 1'b0);
        // enable drops while driving: off the bus at once, no auto_eoi
        begin : enable_drop
            int c0;
            c0 = cyc;
            aeoi = 1'b1; irq_level = 3'd2;
            expect_ev(EV_ISR, 8'h02, c0 + 3);
            expect_ev(EV_SELR, 8'h00, c0 + 7);
            expect_ev(EV_DOER, 8'h4A, c0 + 11);
            expect_ev(EV_DOEF, 8'h00, c0 + 12);
            expect_ev(EV_SELF, 8'h00, c0 + 15);
            cas_in = 3'd3;
            inta_n = 1'b0;
            tick(4);
            inta_n = 1'b1;
            tick(4);
            inta_n = 1'b0;
            tick(4);
            enable = 1'b0;
            inta_n = 1'b1;
            #1;
            check("enable_drop_oe", {31'd0, data_oe}, 32'd0);
            check("enable_drop_data", {24'd0, data_out}, 32'd0);
            tick(6);
            enable = 1'b1;
            aeoi = 1'b0;
        end
        // reset during INTA2, then normal operation resumes
        irq_level = 3'd2;
        reset_mid(3'd2, 8'h4A);
        irq_level = 3'd2;
        two_pulse(3'd3, 1'b1, 3'd2, 1'b1, 8'h4A, 1'b0);
`endif

        tick(5);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing %s: got no event, required val %0h at cycle %0d",
                     ev_name(exp_q[0].kind), exp_q[0].val, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
